// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_pkg
//  Description : Shared types and constants for the two-master data memory
//                arbiter (master identifiers, arbitration mode encodings).
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_arb_pkg;

    // Identifies which requester owns a grant or an outstanding read
    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_t;

    // Arbitration mode encodings for PRIO_MODE
    localparam int RR    = 0;
    localparam int FIXED = 1;

    // Bus widths on the requester side
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    // Returns the master that is not m
    function automatic master_t other_master(input master_t m);
        return (m == M0) ? M1 : M0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-requester combinational grant generator. Round-robin
//                via a last-granted pointer, or fixed priority to requester 0
//                with a starvation counter that force-grants requester 1.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2
    import dmem_arb_pkg::*;
#(
    parameter int PRIO_MODE  = RR,
    parameter int STARVE_MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

    localparam logic [7:0] c_starve_max = 8'(STARVE_MAX);

    master_t    r_last;
    logic [7:0] r_starve_cnt;
    logic       w_force;

    // Requester 1 has waited the maximum number of cycles and must win now
    assign w_force = (PRIO_MODE == FIXED) && i_req1 && (r_starve_cnt == c_starve_max);

    // Grant decision; nothing is granted while reset is held
    always_comb begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        if (!rst) begin
            if (i_req0 && i_req1) begin
                if (PRIO_MODE == FIXED) begin
                    o_gnt1 = w_force;
                    o_gnt0 = !w_force;
                end else begin
                    // Conflict goes to whoever did not win last time
                    o_gnt0 = (other_master(r_last) == M0);
                    o_gnt1 = (other_master(r_last) == M1);
                end
            end else begin
                o_gnt0 = i_req0;
                o_gnt1 = i_req1;
            end
        end
    end

    // Last-granted pointer and starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last       <= M1;
            r_starve_cnt <= '0;
        end else begin
            if (o_gnt0) begin
                r_last <= M0;
            end else if (o_gnt1) begin
                r_last <= M1;
            end
            // Counter cannot pass c_starve_max: equality forces a grant,
            // which clears it on the following edge
            if ((PRIO_MODE == FIXED) && i_req1 && !o_gnt1) begin
                r_starve_cnt <= r_starve_cnt + 8'd1;
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb
//  Description : Shares the single-port data memory between the processor
//                data port (master 0) and a second bus master (master 1).
//                Grants one access per cycle, muxes the memory port, blocks
//                out-of-range writes and routes read data back one cycle
//                later to the master that issued the read.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int DMEM_DEPTH = 13,
    parameter int PRIO_MODE  = RR,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_W-1:0]     m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic                  mem_we,
    output logic [DMEM_DEPTH-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  oor_err
);

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_any_gnt;
    master_t           w_sel;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_oor;
    logic              w_rvalid;
    logic [DATA_W-1:0] w_rdata;

    logic              r_rd_pend;
    master_t           r_rd_owner;
    logic              r_rd_oor;

    rr_arb2 #(
        .PRIO_MODE  (PRIO_MODE),
        .STARVE_MAX (STARVE_MAX)
    ) u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .i_req0 (m0_req),
        .i_req1 (m1_req),
        .o_gnt0 (w_gnt0),
        .o_gnt1 (w_gnt1)
    );

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign w_any_gnt = w_gnt0 || w_gnt1;

    // Master 0 drives the port unless master 1 holds the grant
    always_comb begin
        w_sel   = M0;
        w_we    = m0_we;
        w_addr  = m0_addr;
        w_wdata = m0_wdata;
        if (w_gnt1) begin
            w_sel   = M1;
            w_we    = m1_we;
            w_addr  = m1_addr;
            w_wdata = m1_wdata;
        end
    end

    // Any address bit above the memory depth marks the access out of range
    if (DMEM_DEPTH < ADDR_W) begin : g_oor_chk
        assign w_oor = |w_addr[ADDR_W-1:DMEM_DEPTH];
    end else begin : g_oor_none
        assign w_oor = 1'b0;
    end

    assign mem_addr  = w_addr[DMEM_DEPTH-1:0];
    assign mem_wdata = w_wdata;
    assign mem_we    = w_any_gnt && w_we && !w_oor;
    assign oor_err   = w_any_gnt && w_oor;

    // Read return pipeline: remember who asked and whether it was out of range
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= M0;
            r_rd_oor   <= 1'b0;
        end else begin
            r_rd_pend  <= w_any_gnt && !w_we;
            r_rd_owner <= w_sel;
            r_rd_oor   <= w_oor;
        end
    end

    // Reset in the return cycle kills the response as well
    assign w_rvalid  = r_rd_pend && !rst;
    assign w_rdata   = r_rd_oor ? '0 : mem_rdata;

    assign m0_rvalid = w_rvalid && (r_rd_owner == M0);
    assign m1_rvalid = w_rvalid && (r_rd_owner == M1);
    assign m0_rdata  = m0_rvalid ? w_rdata : '0;
    assign m1_rdata  = m1_rvalid ? w_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arb
//  Description : Self-checking bench for dmem_arb. Instance 0 runs
//                round-robin, instance 1 fixed priority with STARVE_MAX=3.
//                A table of directed vectors, a starvation sequence and
//                random traffic are checked against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_arb;

    localparam int DEPTH     = 13;
    localparam int MEM_WORDS = 1 << DEPTH;
    localparam int FX_STARVE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_fill = 1'b1;

    logic        rq0 [2];
    logic        we0 [2];
    logic [15:0] ad0 [2];
    logic [15:0] wd0 [2];
    logic        rq1 [2];
    logic        we1 [2];
    logic [15:0] ad1 [2];
    logic [15:0] wd1 [2];
    logic        g0  [2];
    logic        g1  [2];
    logic        rv0 [2];
    logic        rv1 [2];
    logic [15:0] rd0 [2];
    logic [15:0] rd1 [2];
    logic        mwe [2];
    logic [12:0] maddr [2];
    logic [15:0] mwd [2];
    logic [15:0] mrd [2];
    logic        oor [2];

    logic [15:0] env_mem [2][MEM_WORDS];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_arb #(.DMEM_DEPTH(DEPTH), .PRIO_MODE(0), .STARVE_MAX(8)) u_dut_rr (
        .clk(clk), .rst(rst),
        .m0_req(rq0[0]), .m0_we(we0[0]), .m0_addr(ad0[0]), .m0_wdata(wd0[0]),
        .m0_gnt(g0[0]), .m0_rvalid(rv0[0]), .m0_rdata(rd0[0]),
        .m1_req(rq1[0]), .m1_we(we1[0]), .m1_addr(ad1[0]), .m1_wdata(wd1[0]),
        .m1_gnt(g1[0]), .m1_rvalid(rv1[0]), .m1_rdata(rd1[0]),
        .mem_we(mwe[0]), .mem_addr(maddr[0]), .mem_wdata(mwd[0]),
        .mem_rdata(mrd[0]), .oor_err(oor[0])
    );

    dmem_arb #(.DMEM_DEPTH(DEPTH), .PRIO_MODE(1), .STARVE_MAX(FX_STARVE)) u_dut_fx (
        .clk(clk), .rst(rst),
        .m0_req(rq0[1]), .m0_we(we0[1]), .m0_addr(ad0[1]), .m0_wdata(wd0[1]),
        .m0_gnt(g0[1]), .m0_rvalid(rv0[1]), .m0_rdata(rd0[1]),
        .m1_req(rq1[1]), .m1_we(we1[1]), .m1_addr(ad1[1]), .m1_wdata(wd1[1]),
        .m1_gnt(g1[1]), .m1_rvalid(rv1[1]), .m1_rdata(rd1[1]),
        .mem_we(mwe[1]), .mem_addr(maddr[1]), .mem_wdata(mwd[1]),
        .mem_rdata(mrd[1]), .oor_err(oor[1])
    );

    function automatic logic [15:0] init_val(input int a);
        return (a == 5) ? 16'h1234 : (16'(a) ^ 16'hA5C3);
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    // Single-port memory for each instance: synchronous write, read data next cycle
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_fill) begin
                for (int i = 0; i < MEM_WORDS; i++) env_mem[k][i] <= init_val(i);
            end else if (mwe[k]) begin
                env_mem[k][maddr[k]] <= mwd[k];
            end
            mrd[k] <= env_mem[k][maddr[k]];
        end
    end

    // ------------------------------------------------------------------
    // Behavioural reference: winner chosen from the arbitration rules,
    // expected memory contents kept separately, one pending read per DUT.
    // ------------------------------------------------------------------
    int          m_last [2] = '{1, 1};
    int          m_cnt  [2] = '{0, 0};
    int          m_pend [2] = '{-1, -1};
    logic [15:0] m_pdat [2];
    logic [15:0] ref_mem [2][MEM_WORDS];
    bit          ref_ready = 1'b0;

    always @(negedge clk) begin : ref_model
        int   win, a, wdat;
        bit   we_s, oor_s, erv0, erv1;
        if (!ref_ready) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < MEM_WORDS; i++) ref_mem[k][i] = init_val(i);
            ref_ready = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            win = -1;
            if (!rst) begin
                if (rq0[k] && rq1[k]) begin
                    if (k == 0) win = 1 - m_last[k];
                    else        win = (m_cnt[k] == FX_STARVE) ? 1 : 0;
                end else if (rq0[k]) begin
                    win = 0;
                end else if (rq1[k]) begin
                    win = 1;
                end
            end
            a     = (win == 1) ? int'(ad1[k]) : int'(ad0[k]);
            wdat  = (win == 1) ? int'(wd1[k]) : int'(wd0[k]);
            we_s  = (win == 1) ? we1[k] : we0[k];
            oor_s = (win >= 0) && (a >= MEM_WORDS);
            erv0  = !rst && (m_pend[k] == 0);
            erv1  = !rst && (m_pend[k] == 1);

            chk("m_gnt0",    k, 32'(g0[k]),    32'(win == 0));
            chk("m_gnt1",    k, 32'(g1[k]),    32'(win == 1));
            chk("m_mem_addr",k, 32'(maddr[k]), 32'(a % MEM_WORDS));
            chk("m_mem_wdat",k, 32'(mwd[k]),   32'(wdat));
            chk("m_mem_we",  k, 32'(mwe[k]),   32'((win >= 0) && we_s && !oor_s));
            chk("m_oor_err", k, 32'(oor[k]),   32'(oor_s));
            chk("m_rvalid0", k, 32'(rv0[k]),   32'(erv0));
            chk("m_rvalid1", k, 32'(rv1[k]),   32'(erv1));
            chk("m_rdata0",  k, 32'(rd0[k]),   erv0 ? 32'(m_pdat[k]) : 32'd0);
            chk("m_rdata1",  k, 32'(rd1[k]),   erv1 ? 32'(m_pdat[k]) : 32'd0);

            if (rst) begin
                m_last[k] = 1;
                m_cnt[k]  = 0;
                m_pend[k] = -1;
            end else begin
                m_pend[k] = -1;
                if (win >= 0) begin
                    m_last[k] = win;
                    if (!we_s) begin
                        m_pend[k] = win;
                        m_pdat[k] = oor_s ? 16'h0000 : ref_mem[k][a];
                    end else if (!oor_s) begin
                        ref_mem[k][a] = 16'(wdat);
                    end
                end
                if (k == 1 && rq1[k] && win != 1) m_cnt[k] = m_cnt[k] + 1;
                else                              m_cnt[k] = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed vectors for the round-robin instance, one row per cycle
    // ------------------------------------------------------------------
    typedef struct {
        logic        rst;
        logic        r0, w0;
        logic [15:0] a0;
        logic        r1, w1;
        logic [15:0] a1, d1;
        logic        g0, g1, mwe, oor, rv0, rv1;
        logic [15:0] rd0, rd1;
    } vec_t;

    function automatic vec_t mk(
        input logic rs, input logic r0, input logic w0, input logic [15:0] a0,
        input logic r1, input logic w1, input logic [15:0] a1, input logic [15:0] d1,
        input logic eg0, input logic eg1, input logic emwe, input logic eoor,
        input logic erv0, input logic erv1, input logic [15:0] erd0, input logic [15:0] erd1);
        vec_t v;
        v.rst = rs;  v.r0 = r0;  v.w0 = w0;  v.a0 = a0;
        v.r1 = r1;   v.w1 = w1;  v.a1 = a1;  v.d1 = d1;
        v.g0 = eg0;  v.g1 = eg1; v.mwe = emwe; v.oor = eoor;
        v.rv0 = erv0; v.rv1 = erv1; v.rd0 = erd0; v.rd1 = erd1;
        return v;
    endfunction

    localparam int NV = 22;
    vec_t tbl [NV];

    task automatic idle_inputs(input int k);
        rq0[k] = 0; we0[k] = 0; ad0[k] = '0; wd0[k] = '0;
        rq1[k] = 0; we1[k] = 0; ad1[k] = '0; wd1[k] = '0;
    endtask

    initial begin
        logic [7:0] fx_pat;
        idle_inputs(0);
        idle_inputs(1);

        //             rst r0 w0 a0        r1 w1 a1        d1        g0 g1 we oor rv0 rv1 rd0      rd1
        tbl[0]  = mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        tbl[1]  = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        tbl[2]  = mk(0, 1, 0, 16'h0005, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        tbl[3]  = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 0, 16'h1234, 16'h0000);
        tbl[4]  = mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        tbl[5]  = mk(0, 1, 0, 16'h0010, 1, 0, 16'h0020, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        tbl[6]  = mk(0, 1, 0, 16'h0010, 1, 0, 16'h0020, 16'h0000, 0, 1, 0, 0, 1, 0, 16'hA5D3, 16'h0000);
        tbl[7]  = mk(0, 1, 0, 16'h0010, 1, 0, 16'h0020, 16'h0000, 1, 0, 0, 0, 0, 1, 16'h0000, 16'hA5E3);
        tbl[8]  = mk(0, 1, 0, 16'h0010, 1, 0, 16'h0020, 16'h0000, 0, 1, 0, 0, 1, 0, 16'hA5D3, 16'h0000);
        tbl[9]  = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h0000, 16'hA5E3);
        tbl[10] = mk(0, 0, 0, 16'h0000, 1, 1, 16'h2000, 16'hBEEF, 0, 1, 0, 1, 0, 0, 16'h0000, 16'h0000);
        tbl[11] = mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        tbl[12] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 0, 16'hA5C3, 16'h0000);
        tbl[13] = mk(0, 1, 0, 16'hC001, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 1, 0, 0, 16'h0000, 16'h0000);
        tbl[14] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000);
        tbl[15] = mk(0, 1, 0, 16'h0005, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        tbl[16] = mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        tbl[17] = mk(0, 1, 0, 16'h0010, 1, 0, 16'h0020, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        tbl[18] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 0, 16'hA5D3, 16'h0000);
        tbl[19] = mk(0, 0, 0, 16'h0000, 1, 1, 16'h0030, 16'hCAFE, 0, 1, 1, 0, 0, 0, 16'h0000, 16'h0000);
        tbl[20] = mk(0, 0, 0, 16'h0000, 1, 0, 16'h0030, 16'h0000, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000);
        tbl[21] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h0000, 16'hCAFE);

        // First cycle loads the memories
        @(posedge clk);
        #1 mem_fill = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            rst    = tbl[i].rst;
            rq0[0] = tbl[i].r0; we0[0] = tbl[i].w0; ad0[0] = tbl[i].a0; wd0[0] = 16'h0000;
            rq1[0] = tbl[i].r1; we1[0] = tbl[i].w1; ad1[0] = tbl[i].a1; wd1[0] = tbl[i].d1;
            @(negedge clk);
            chk($sformatf("v%0d_gnt0", i),   0, 32'(g0[0]),  32'(tbl[i].g0));
            chk($sformatf("v%0d_gnt1", i),   0, 32'(g1[0]),  32'(tbl[i].g1));
            chk($sformatf("v%0d_mem_we", i), 0, 32'(mwe[0]), 32'(tbl[i].mwe));
            chk($sformatf("v%0d_oor", i),    0, 32'(oor[0]), 32'(tbl[i].oor));
            chk($sformatf("v%0d_rv0", i),    0, 32'(rv0[0]), 32'(tbl[i].rv0));
            chk($sformatf("v%0d_rv1", i),    0, 32'(rv1[0]), 32'(tbl[i].rv1));
            chk($sformatf("v%0d_rd0", i),    0, 32'(rd0[0]), 32'(tbl[i].rd0));
            chk($sformatf("v%0d_rd1", i),    0, 32'(rd1[0]), 32'(tbl[i].rd1));
        end
        idle_inputs(0);

        // Fixed priority with STARVE_MAX=3: master 1 wins cycles 3 and 7
        @(posedge clk);
        #1 rst = 1'b1;
        fx_pat = 8'b1000_1000;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            rq0[1] = 1; we0[1] = 0; ad0[1] = 16'h0040;
            rq1[1] = 1; we1[1] = 0; ad1[1] = 16'h0041;
            @(negedge clk);
            chk($sformatf("fx_c%0d_gnt1", i), 1, 32'(g1[1]), 32'(fx_pat[i]));
            chk($sformatf("fx_c%0d_gnt0", i), 1, 32'(g0[1]), 32'(!fx_pat[i]));
        end
        idle_inputs(1);

        // Random traffic on both instances; the reference model checks each cycle
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 149) == 0);
            for (int k = 0; k < 2; k++) begin
                rq0[k] = ($urandom_range(0, 3) != 0);
                rq1[k] = ($urandom_range(0, 3) != 0);
                we0[k] = ($urandom_range(0, 2) == 0);
                we1[k] = ($urandom_range(0, 2) == 0);
                ad0[k] = ($urandom_range(0, 9) == 0) ? (16'($urandom) | 16'h2000) : 16'($urandom_range(0, 31));
                ad1[k] = ($urandom_range(0, 9) == 0) ? (16'($urandom) | 16'h2000) : 16'($urandom_range(0, 31));
                wd0[k] = 16'($urandom);
                wd1[k] = 16'($urandom);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs(0);
        idle_inputs(1);
        repeat (2) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arb.md
# dmem_arb

Two-master arbiter sharing the single-port data memory (`dmem`) between the processor data port (master 0) and a second bus master (master 1, e.g. a program loader or DMA engine). It sits between the requesters and `dmem`, ahead of the MMIO decode. Each cycle it grants at most one request, drives the memory port, suppresses writes beyond `DMEM_DEPTH`, and returns read data one cycle later, tagged to the master that issued the read.

## Interface
- `DMEM_DEPTH`, 13: memory address width; valid addresses are 0 .. 2^DMEM_DEPTH-1.
- `PRIO_MODE`, 0: 0 = round-robin; 1 = fixed priority to master 0 with starvation guard.
- `STARVE_MAX`, 8: in `PRIO_MODE`=1, the number of consecutive cycles master 1 may be denied before it is force-granted (1..255).
- Reset is synchronous, active-high, sampled on the rising edge of `clk`.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `m0_req`, `m1_req`  in  1  access request, held until granted
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read
- `m0_addr`, `m1_addr`  in  16  word address
- `m0_wdata`, `m1_wdata`  in  16  write data
- `m0_gnt`, `m1_gnt`  out  1  request accepted this cycle (combinational)
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid
- `m0_rdata`, `m1_rdata`  out  16  read data
- `mem_we`  out  1  to `dmem` `we_i`
- `mem_addr`  out  DMEM_DEPTH  to `dmem` `addr_i`
- `mem_wdata`  out  16  to `dmem` `wdata_i`
- `mem_rdata`  in  16  from `dmem` `rdata_o`; valid the cycle after the address is presented
- `oor_err`  out  1  one-cycle pulse when a granted access had any of `addr[15:DMEM_DEPTH]` set

## Operation
- **Grant.** At most one grant per cycle. A master with no request is never granted. If only one master requests, it is granted.
- **Round-robin (`PRIO_MODE`=0).** The `last` register holds the most recently granted master; reset value is 1, so master 0 wins the first conflict. When both masters request, the master other than `last` is granted. `last` updates only on a grant.
- **Fixed priority (`PRIO_MODE`=1).**
  - Master 0 wins conflicts.
  - `starve_cnt` (8 bits) increments each cycle master 1 requests and is not granted. It clears when master 1 is granted or drops `req`.
  - When `starve_cnt` == `STARVE_MAX`, master 1 is granted regardless of master 0.
- **Memory port.** `mem_addr`, `mem_wdata` and `mem_we` are muxed from the granted master. With no grant, `mem_we`=0 and `mem_addr`/`mem_wdata` hold the master 0 values.
- **Out of range.** If `|addr[15:DMEM_DEPTH]` is true for a granted access:
  - `mem_we` is forced to 0.
  - `oor_err` pulses in the grant cycle.
  - A read in this case returns 0x0000 with normal `rvalid` timing.
- **Read return.** Pipeline registers capture `rd_pend`, `rd_owner` and `rd_oor` at the grant. Next cycle, `mX_rvalid`=1 for the owner only, and `mX_rdata` = `mem_rdata`, or 0 if `rd_oor`. Non-owner `rdata` is 0.
- **Write.** Completes at the grant edge. No response is returned.

## Timing
- Grant to memory port: same cycle, combinational.
- Read latency: `rvalid` in cycle N+1 for a grant in cycle N. Back-to-back reads sustain one per cycle, including alternating masters.
- **Reset.** The following outputs are 0 during and after reset until a request arrives:
  - all `gnt`, `rvalid`, `rdata`
  - `mem_we`, `oor_err`
- **Reset state of registers.** `last`=1, `starve_cnt`=0, `rd_pend`=0.
- **Reset mid-read.** A reset asserted in the cycle after a read grant suppresses that `rvalid`.
- **Request withdrawal.** A request deasserted before being granted is dropped silently. The arbiter does not check that requests are held.

## Structure
- Shared package `dmem_arb_pkg`:
  - `typedef enum logic {M0, M1} master_t`
  - localparams `RR`=0 and `FIXED`=1
- Sub-module `rr_arb2`: a two-requester grant generator with a `last` pointer and an optional starvation counter. `dmem_arb` instantiates it once.
- Return pipeline, out-of-range check and memory mux live in `dmem_arb`.

## Test plan
- **Solo read.** Reset, `m0_req` read addr 0x0005 with the memory model returning 0x1234 → `m0_gnt`=1 in cycle 0; `m0_rvalid`=1 and `m0_rdata`=0x1234 in cycle 1; `m1_rvalid`=0.
- **Round-robin conflict.** Both masters request reads continuously for 4 cycles → grants in the order M0, M1, M0, M1; `rvalid` owners follow one cycle later.
- **Fixed-priority starvation.** `PRIO_MODE`=1, `STARVE_MAX`=3, both requesting continuously → M0 granted in cycles 0–2, M1 in cycle 3, M0 in cycles 4–6, M1 in cycle 7.
- **Out-of-range write.** `m1` writes 0x2000 with data 0xBEEF (`DMEM_DEPTH`=13) → `m1_gnt`=1, `mem_we`=0, `oor_err` pulses; a subsequent read of 0x0000 returns unchanged data.
- **Out-of-range read.** `m0` reads 0xC001 → `oor_err`=1, `m0_rvalid`=1 next cycle with `m0_rdata`=0x0000.
- **Reset mid-read.** A read is granted in cycle 0 and `rst`=1 in cycle 1 → no `rvalid` in cycle 1; `last`=1 and `starve_cnt`=0 afterwards.
